// File: rtl/mul_div_8051.sv
// Iterative 8051 MUL AB / DIV AB sequencer that time-shares the core 8-bit ALU adder.
// Define MUL_DIV_8051_DIV_EN to include DIV AB; otherwise OP=1 completes at once with OV set.
module mul_div_8051 (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       OP,
    input  logic [7:0] ACC_IN,
    input  logic [7:0] B_IN,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] ACC_OUT,
    output logic [7:0] B_OUT,
    output logic       OV_OUT,
    output logic [7:0] ADD_A,
    output logic [7:0] ADD_B,
    output logic       ADD_CI,
    input  logic [7:0] ADD_SUM,
    input  logic       ADD_CO
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] hi, hi_nxt;
    logic [7:0] lo, lo_nxt;
    logic [7:0] opr, opr_nxt;
    logic       opl, opl_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [7:0] acc_q, acc_nxt;
    logic [7:0] b_q, b_nxt;
    logic       ov_q, ov_nxt;
    logic [7:0] iter_hi, iter_lo;
`ifdef MUL_DIV_8051_DIV_EN
    logic [7:0] shifted_rem;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            hi    <= 8'h00;
            lo    <= 8'h00;
            opr   <= 8'h00;
            opl   <= 1'b0;
            cnt   <= 3'd0;
            acc_q <= 8'h00;
            b_q   <= 8'h00;
            ov_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            opr   <= opr_nxt;
            opl   <= opl_nxt;
            cnt   <= cnt_nxt;
            acc_q <= acc_nxt;
            b_q   <= b_nxt;
            ov_q  <= ov_nxt;
        end
    end

    // One iteration step: the adder is driven only in RUN and its result feeds {HI,LO} directly.
    always_comb begin
        ADD_A   = 8'h00;
        ADD_B   = 8'h00;
        ADD_CI  = 1'b0;
        iter_hi = hi;
        iter_lo = lo;
`ifdef MUL_DIV_8051_DIV_EN
        shifted_rem = {hi[6:0], lo[7]};
`endif
        if (state == S_RUN) begin
`ifdef MUL_DIV_8051_DIV_EN
            if (opl) begin
                ADD_A  = shifted_rem;
                ADD_B  = ~opr;
                ADD_CI = 1'b1;
                if (hi[7] | ADD_CO) begin
                    iter_hi = ADD_SUM;
                    iter_lo = {lo[6:0], 1'b1};
                end else begin
                    iter_hi = shifted_rem;
                    iter_lo = {lo[6:0], 1'b0};
                end
            end else begin
`else
            begin
`endif
                ADD_A  = hi;
                ADD_B  = opr;
                ADD_CI = 1'b0;
                if (lo[0]) begin
                    {iter_hi, iter_lo} = {ADD_CO, ADD_SUM, lo[7:1]};
                end else begin
                    {iter_hi, iter_lo} = {1'b0, hi, lo[7:1]};
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        hi_nxt    = hi;
        lo_nxt    = lo;
        opr_nxt   = opr;
        opl_nxt   = opl;
        cnt_nxt   = cnt;
        acc_nxt   = acc_q;
        b_nxt     = b_q;
        ov_nxt    = ov_q;
        case (state)
            S_IDLE, S_FIN: begin
                if (START) begin
                    hi_nxt    = 8'h00;
                    lo_nxt    = ACC_IN;
                    opr_nxt   = B_IN;
                    opl_nxt   = OP;
                    cnt_nxt   = 3'd0;
                    state_nxt = S_RUN;
                    // Operations that cannot iterate complete immediately with OV set.
                    if (OP) begin
`ifdef MUL_DIV_8051_DIV_EN
                        if (B_IN == 8'h00) begin
                            state_nxt = S_FIN;
                            acc_nxt   = ACC_IN;
                            b_nxt     = 8'h00;
                            ov_nxt    = 1'b1;
                        end
`else
                        state_nxt = S_FIN;
                        acc_nxt   = ACC_IN;
                        b_nxt     = B_IN;
                        ov_nxt    = 1'b1;
`endif
                    end
                end else if (state == S_FIN) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                hi_nxt  = iter_hi;
                lo_nxt  = iter_lo;
                cnt_nxt = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    state_nxt = S_FIN;
                    acc_nxt   = iter_lo;
                    b_nxt     = iter_hi;
                    ov_nxt    = ~opl & (|iter_hi);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign BUSY    = (state == S_RUN);
    assign DONE    = (state == S_FIN);
    assign ACC_OUT = acc_q;
    assign B_OUT   = b_q;
    assign OV_OUT  = ov_q;

endmodule
